// File: rtl/lc3b_types.sv
// Shared L1 cache types: default index/tag widths, line size and way-array FSM states.
package lc3b_types;

  typedef logic [2:0] lc3b_l1_index;
  typedef logic [8:0] lc3b_l1_tag;

  localparam int L1_LINE_BYTES = 16;

  typedef enum logic {
    WAY_IDLE  = 1'b0,
    WAY_SWEEP = 1'b1
  } l1_way_state_e;

endpackage

// File: rtl/masked_line_ram.sv
// DEPTH x WIDTH line storage with per-byte write enables and a combinational read port.
module masked_line_ram #(
  parameter  int WIDTH  = 128,
  parameter  int DEPTH  = 8,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int NBYTES = WIDTH / 8
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic [NBYTES-1:0] byte_we_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [IDX_W-1:0]  rd_index_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is deliberately left unreset; only the enabled bytes of the addressed line change.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_we_i[b]) begin
        mem_q[wr_index_i][8*b +: 8] <= wr_data_i[8*b +: 8];
      end
    end
  end

  assign rd_data_o = mem_q[rd_index_i];

endmodule

// File: rtl/l1_way_array.sv
// One L1 cache way: masked line data, tag, valid/dirty, 1-cycle read with write bypass,
// and a DEPTH-cycle invalidate-all sweep during which requests are refused.
module l1_way_array
  import lc3b_types::*;
#(
  parameter  int WIDTH = 128,
  parameter  int DEPTH = 8,
  parameter  int TAG_W = 9,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_index,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH/8-1:0] wr_mask,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_dirty,
  input  logic               inv_all,
  output logic               ready,
  output logic               rd_valid_out,
  output logic [WIDTH-1:0]   rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_hitvalid,
  output logic               rd_dirty
);

  localparam int NBYTES = WIDTH / 8;

  l1_way_state_e    state_q, state_d;
  logic [IDX_W-1:0] ctr_q, ctr_d;
  logic             ready_q, ready_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q [DEPTH];

  logic              rd_acc_s, wr_acc_s, bypass_s;
  logic [NBYTES-1:0] ram_we_s;
  logic [WIDTH-1:0]  ram_rdata_s, merged_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic              rd_hit_s, rd_dirty_s;

  logic              rd_valid_q;
  logic [WIDTH-1:0]  rd_data_q;
  logic [TAG_W-1:0]  rd_tag_q;
  logic              rd_hit_q, rd_dirty_q;

  assign rd_acc_s = rd_en & ready_q;
  assign wr_acc_s = wr_en & ready_q;
  assign bypass_s = rd_acc_s & wr_acc_s & (rd_index == wr_index);
  assign ram_we_s = wr_acc_s ? wr_mask : {NBYTES{1'b0}};

  masked_line_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk        (clk),
    .wr_index_i (wr_index),
    .byte_we_i  (ram_we_s),
    .wr_data_i  (wr_data),
    .rd_index_i (rd_index),
    .rd_data_o  (ram_rdata_s)
  );

  // Tag storage, unreset like the data lines.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  // Read view of the set: a same-index write overrides masked bytes, tag, valid and dirty.
  always_comb begin
    merged_s = ram_rdata_s;
    for (int b = 0; b < NBYTES; b++) begin
      if (bypass_s && wr_mask[b]) begin
        merged_s[8*b +: 8] = wr_data[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = ram_rdata_s[8*b +: 8];
      end
    end
    if (bypass_s) begin
      rd_tag_s   = wr_tag;
      rd_hit_s   = 1'b1;
      rd_dirty_s = wr_dirty;
    end else begin
      rd_tag_s   = tag_q[rd_index];
      rd_hit_s   = valid_q[rd_index];
      rd_dirty_s = dirty_q[rd_index];
    end
  end

  // Next-state: sweep sequencing plus valid/dirty updates from writes and the sweep.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    case (state_q)
      WAY_IDLE: begin
        if (inv_all) begin
          state_d = WAY_SWEEP;
          ctr_d   = {IDX_W{1'b0}};
        end else begin
          state_d = WAY_IDLE;
        end
        if (wr_acc_s) begin
          valid_d[wr_index] = 1'b1;
          dirty_d[wr_index] = wr_dirty;
        end else begin
          valid_d = valid_q;
        end
      end
      WAY_SWEEP: begin
        valid_d[ctr_q] = 1'b0;
        dirty_d[ctr_q] = 1'b0;
        ctr_d          = ctr_q + IDX_W'(1);
        if (ctr_q == IDX_W'(DEPTH - 1)) begin
          state_d = WAY_IDLE;
        end else begin
          state_d = WAY_SWEEP;
        end
      end
      default: begin
        state_d = WAY_IDLE;
      end
    endcase
    ready_d = (state_d == WAY_IDLE);
  end

  // Control and valid/dirty state; reset aborts any sweep and invalidates every set at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAY_IDLE;
      ctr_q   <= {IDX_W{1'b0}};
      ready_q <= 1'b1;
      valid_q <= {DEPTH{1'b0}};
      dirty_q <= {DEPTH{1'b0}};
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Read output registers; payload holds its last value between read pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= {WIDTH{1'b0}};
      rd_tag_q   <= {TAG_W{1'b0}};
      rd_hit_q   <= 1'b0;
      rd_dirty_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc_s;
      if (rd_acc_s) begin
        rd_data_q  <= merged_s;
        rd_tag_q   <= rd_tag_s;
        rd_hit_q   <= rd_hit_s;
        rd_dirty_q <= rd_dirty_s;
      end
    end
  end

  assign ready        = ready_q;
  assign rd_valid_out = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_tag       = rd_tag_q;
  assign rd_hitvalid  = rd_hit_q;
  assign rd_dirty     = rd_dirty_q;

endmodule

// File: tb/tb_l1_way_array.sv
// Directed self-checking bench for l1_way_array with hand-computed expected values.
module tb_l1_way_array;
  import lc3b_types::*;

  logic               clk;
  logic               reset_n;
  logic               rd_en;
  lc3b_l1_index       rd_index;
  logic               wr_en;
  lc3b_l1_index       wr_index;
  logic [127:0]       wr_data;
  logic [15:0]        wr_mask;
  lc3b_l1_tag         wr_tag;
  logic               wr_dirty;
  logic               inv_all;
  logic               ready;
  logic               rd_valid_out;
  logic [127:0]       rd_data;
  lc3b_l1_tag         rd_tag;
  logic               rd_hitvalid;
  logic               rd_dirty;

  int n_chk;
  int n_err;
  int low_cnt;

  l1_way_array #(.WIDTH(128), .DEPTH(8), .TAG_W(9)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_en        (rd_en),
    .rd_index     (rd_index),
    .wr_en        (wr_en),
    .wr_index     (wr_index),
    .wr_data      (wr_data),
    .wr_mask      (wr_mask),
    .wr_tag       (wr_tag),
    .wr_dirty     (wr_dirty),
    .inv_all      (inv_all),
    .ready        (ready),
    .rd_valid_out (rd_valid_out),
    .rd_data      (rd_data),
    .rd_tag       (rd_tag),
    .rd_hitvalid  (rd_hitvalid),
    .rd_dirty     (rd_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    inv_all = 1'b0;
  endtask

  task automatic do_write(input lc3b_l1_index idx, input logic [127:0] d, input logic [15:0] m,
                          input lc3b_l1_tag t, input logic dty);
    wr_en    = 1'b1;
    wr_index = idx;
    wr_data  = d;
    wr_mask  = m;
    wr_tag   = t;
    wr_dirty = dty;
    tick();
    idle_inputs();
  endtask

  task automatic do_read(input lc3b_l1_index idx);
    rd_en    = 1'b1;
    rd_index = idx;
    tick();
    idle_inputs();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset_n = 1'b0;
    rd_index = 3'd0; wr_index = 3'd0; wr_data = 128'd0; wr_mask = 16'd0;
    wr_tag = 9'd0; wr_dirty = 1'b0;
    idle_inputs();
    repeat (2) tick();

    chk("rst_ready", ready, 1'b1);
    chk("rst_rvalid", rd_valid_out, 1'b0);
    chk("rst_data", rd_data, 128'd0);
    chk("rst_tag", rd_tag, 9'd0);
    chk("rst_hit", rd_hitvalid, 1'b0);
    chk("rst_dirty", rd_dirty, 1'b0);
    reset_n = 1'b1;
    tick();

    do_read(3'd3);
    chk("rd3_valid", rd_valid_out, 1'b1);
    chk("rd3_hit", rd_hitvalid, 1'b0);
    chk("rd3_dirty", rd_dirty, 1'b0);
    tick();
    chk("rd3_pulse", rd_valid_out, 1'b0);

    do_write(3'd5, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 9'h1A5, 1'b1);
    chk("wr5_novalid", rd_valid_out, 1'b0);
    do_read(3'd5);
    chk("rd5_valid", rd_valid_out, 1'b1);
    chk("rd5_data", rd_data, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    chk("rd5_tag", rd_tag, 9'h1A5);
    chk("rd5_hit", rd_hitvalid, 1'b1);
    chk("rd5_dirty", rd_dirty, 1'b1);

    do_write(3'd5, {16{8'hEE}}, 16'h0003, 9'h1A5, 1'b0);
    do_read(3'd5);
    chk("mask_data", rd_data, 128'h00112233_44556677_8899AABB_CCDDEEEE);
    chk("mask_dirty", rd_dirty, 1'b0);
    tick();
    chk("hold_valid", rd_valid_out, 1'b0);
    chk("hold_data", rd_data, 128'h00112233_44556677_8899AABB_CCDDEEEE);

    do_write(3'd4, {16{8'h44}}, 16'h0000, 9'h0C3, 1'b1);
    do_read(3'd4);
    chk("mask0_tag", rd_tag, 9'h0C3);
    chk("mask0_hit", rd_hitvalid, 1'b1);
    chk("mask0_dirty", rd_dirty, 1'b1);

    do_write(3'd2, 128'd0, 16'hFFFF, 9'h000, 1'b0);
    wr_en = 1'b1; wr_index = 3'd2; wr_data = {8'hAB, 120'd0}; wr_mask = 16'h8000;
    wr_tag = 9'h055; wr_dirty = 1'b1;
    rd_en = 1'b1; rd_index = 3'd2;
    tick();
    idle_inputs();
    chk("byp_data", rd_data, {8'hAB, 120'd0});
    chk("byp_hit", rd_hitvalid, 1'b1);
    chk("byp_tag", rd_tag, 9'h055);
    chk("byp_dirty", rd_dirty, 1'b1);

    wr_en = 1'b1; wr_index = 3'd6; wr_data = {16{8'h66}}; wr_mask = 16'hFFFF;
    wr_tag = 9'h066; wr_dirty = 1'b0;
    rd_en = 1'b1; rd_index = 3'd5;
    tick();
    idle_inputs();
    chk("indep_data", rd_data, 128'h00112233_44556677_8899AABB_CCDDEEEE);
    chk("indep_tag", rd_tag, 9'h1A5);
    do_read(3'd6);
    chk("indep_wr6", rd_data, {16{8'h66}});

    for (int i = 0; i < 8; i++) begin
      do_write(3'(i), {16{8'(8'h10 + i)}}, 16'hFFFF, 9'(i), 1'b1);
    end
    inv_all = 1'b1; rd_en = 1'b1; rd_index = 3'd1;
    tick();
    idle_inputs();
    chk("inv_same_rd", rd_valid_out, 1'b1);
    chk("inv_same_hit", rd_hitvalid, 1'b1);
    low_cnt = 0;
    for (int c = 0; c < 20 && !ready; c++) begin
      low_cnt++;
      if (c == 2) begin
        rd_en = 1'b1; rd_index = 3'd7;
        wr_en = 1'b1; wr_index = 3'd0; wr_data = {16{8'hFF}}; wr_mask = 16'hFFFF;
        wr_tag = 9'h1FF; wr_dirty = 1'b1;
        inv_all = 1'b1;
      end
      tick();
      if (c == 2) begin
        idle_inputs();
        chk("sweep_drop_rd", rd_valid_out, 1'b0);
      end
    end
    chk("sweep_len", low_cnt, 8);
    chk("sweep_rvalid", rd_valid_out, 1'b0);
    for (int i = 0; i < 8; i++) begin
      do_read(3'(i));
      chk("post_inv_hit", rd_hitvalid, 1'b0);
      chk("post_inv_dirty", rd_dirty, 1'b0);
    end
    do_read(3'd0);
    chk("drop_wr_data", rd_data, {16{8'h10}});
    chk("drop_wr_tag", rd_tag, 9'd0);

    do_write(3'd4, {16{8'h44}}, 16'hFFFF, 9'h004, 1'b1);
    do_write(3'd6, {16{8'h66}}, 16'hFFFF, 9'h006, 1'b1);
    do_write(3'd7, {16{8'h77}}, 16'hFFFF, 9'h007, 1'b1);
    inv_all = 1'b1;
    tick();
    idle_inputs();
    repeat (3) tick();
    chk("mid_sweep_busy", ready, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_ready", ready, 1'b1);
    chk("rst_mid_rvalid", rd_valid_out, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    do_read(3'd4);
    chk("rst_mid_hit4", rd_hitvalid, 1'b0);
    do_read(3'd6);
    chk("rst_mid_hit6", rd_hitvalid, 1'b0);
    do_read(3'd7);
    chk("rst_mid_hit7", rd_hitvalid, 1'b0);
    chk("rst_mid_dirty7", rd_dirty, 1'b0);

    inv_all = 1'b1;
    tick();
    idle_inputs();
    low_cnt = 0;
    for (int c = 0; c < 20 && !ready; c++) begin
      low_cnt++;
      tick();
    end
    chk("resweep_len", low_cnt, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/l1_way_array.md
Name: l1_way_array

Overview:
- Parametrised successor to the single-port L1 data array: one cache way holding data, tag, valid and dirty per set.
- Adds byte-masked writes, a registered 1-cycle read with same-cycle write bypass, and a multi-cycle invalidate-all sweep.
- Sits under the L1 cache controller, instantiated once per way; the controller compares tags and drives LRU.

Parameters:
- WIDTH, 128, data line width in bits; must be a multiple of 8.
- DEPTH, 8, number of sets; power of two, at least 2.
- TAG_W, 9, tag width in bits.
- IDX_W, $clog2(DEPTH), index width; derived, never overridden.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rd_en  in  1  read request.
- rd_index  in  IDX_W  read set.
- wr_en  in  1  write request.
- wr_index  in  IDX_W  write set.
- wr_data  in  WIDTH  write data.
- wr_mask  in  WIDTH/8  byte enables; bit i covers data[8i+7:8i].
- wr_tag  in  TAG_W  tag written on every accepted write.
- wr_dirty  in  1  value loaded into the dirty bit on write.
- inv_all  in  1  start-invalidate pulse.
- ready  out  1  high when reads and writes are accepted.
- rd_valid_out  out  1  one-cycle pulse: read data is valid.
- rd_data  out  WIDTH  read line.
- rd_tag  out  TAG_W  read tag.
- rd_hitvalid  out  1  valid bit of the read set.
- rd_dirty  out  1  dirty bit of the read set.

Behaviour:
- Reset (async assert, sync deassert is external): all valid and dirty bits = 0; FSM = IDLE; ready = 1; rd_valid_out, rd_hitvalid and rd_dirty = 0; rd_data and rd_tag = 0. Data and tag storage are not reset.
- FSM states: IDLE and SWEEP.
  - IDLE -> SWEEP when inv_all = 1. The sweep counter loads 0 and ready drops the next cycle.
  - In SWEEP, each cycle clears valid[ctr] and dirty[ctr], then ctr increments.
  - SWEEP -> IDLE after clearing entry DEPTH-1. The sweep takes exactly DEPTH cycles; ready returns to 1 the cycle after the last clear.
  - inv_all during SWEEP is ignored; the sweep does not restart.
- Requests are accepted only when ready = 1. In the same cycle inv_all is sampled in IDLE, pending rd_en and wr_en are still accepted. While ready = 0, rd_en and wr_en are dropped silently and rd_valid_out stays 0.
- Write (accepted wr_en), applied at the clock edge:
  - for each set bit in wr_mask, update that data byte;
  - tag[wr_index] <= wr_tag; valid <= 1; dirty <= wr_dirty.
  - wr_mask = 0 still updates tag, valid and dirty.
- Read (accepted rd_en): latency 1. On the next cycle rd_valid_out = 1 and rd_data, rd_tag, rd_hitvalid and rd_dirty show the set contents.
- Same-cycle read and write, same index: the read returns post-write contents. Masked bytes come from wr_data, unmasked bytes from old storage; tag, valid and dirty come from the write.
- Different indices: the read and write are independent.
- Read outputs hold their last values when rd_valid_out = 0.
- Reset asserted mid-sweep: the FSM returns to IDLE and all valid bits clear immediately.

Decomposition:
- Package lc3b_types:
  - add lc3b_l1_tag (TAG_W bits);
  - reuse lc3b_l1_index for the default DEPTH=8;
  - add localparam L1_LINE_BYTES = 16.
- Sub-module masked_line_ram: DEPTH x WIDTH storage with per-byte write enable and an asynchronous read port. The wrapper holds tag, valid/dirty flops, bypass merge, output registers and the FSM.

Test Plan:
- Reset, then read index 3 -> one cycle later rd_valid_out = 1, rd_hitvalid = 0, rd_dirty = 0.
- Write idx 5, data 0x00112233_44556677_8899AABB_CCDDEEFF, mask 0xFFFF, tag 0x1A5, dirty 1; read idx 5 next cycle -> same data, rd_tag = 0x1A5, rd_hitvalid = 1, rd_dirty = 1, one cycle after rd_en.
- Write idx 5, data all 0xEE, mask 0x0003; read -> data 0x00112233_44556677_8899AABB_CCDDEEEE.
- Same cycle: write idx 2, mask 0x8000, data 0xAB in the top byte, together with read idx 2 (old line all zero) -> rd_data = 0xAB000000_..._00000000, rd_hitvalid = 1.
- Write all 8 sets, pulse inv_all -> ready = 0 for exactly 8 cycles; rd_en and wr_en pulsed mid-sweep give no rd_valid_out and no change; afterwards every set reads rd_hitvalid = 0.
- Assert reset_n low during sweep cycle 4 -> ready = 1 immediately, all valid bits 0; after release, a new inv_all runs a full 8-cycle sweep.
